// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus-written bytes queue in a small FIFO
// and are serialized LSB first on tx, with a programmable baud divisor.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 868,
  parameter int unsigned DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [DIV_W-1:0] baud_div_q, baud_div_d;
  logic [DIV_W-1:0] frame_div_q, frame_div_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic wr_txdata_s, wr_status_s, wr_baud_s;
  logic full_s, empty_s, busy_s, bit_end_s;
  logic push_s, pop_s;
  logic [3:0] count4_s;
  logic unused_wdata_s;

  assign wr_txdata_s = sel & we & (addr == 4'h0);
  assign wr_status_s = sel & we & (addr == 4'h4);
  assign wr_baud_s   = sel & we & (addr == 4'h8);

  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == CNT_ZERO);
  assign busy_s    = (state_q != ST_IDLE);
  assign bit_end_s = (tick_q == DIV_ZERO);
  assign count4_s  = 4'(count_q);

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
  assign push_s = wr_txdata_s & ~full_s;
  assign pop_s  = ~empty_s & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end_s));

  assign ready = sel;
  assign tx    = tx_q;
  assign irq   = empty_s & (state_q == ST_IDLE);
  assign unused_wdata_s = ^wdata;

  // Register read mux, combinational from the offset.
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      4'h4:    rdata = {20'h0_0000, count4_s, 4'h0, overflow_q, empty_s, full_s, busy_s};
      4'h8:    rdata = 32'(baud_div_q);
      default: rdata = 32'h0000_0000;
    endcase
  end

  // FIFO pointer, count, overflow and divisor register next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    baud_div_d = baud_div_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (wr_txdata_s && full_s) begin
      overflow_d = 1'b1;
    end else if (wr_status_s && wdata[3]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (wr_baud_s) begin
      baud_div_d = (wdata[DIV_W-1:0] == DIV_ZERO) ? DIV_ONE : wdata[DIV_W-1:0];
    end else begin
      baud_div_d = baud_div_q;
    end
  end

  // Frame sequencer: the divisor is captured per frame so mid-frame writes wait for the next START.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_div_d = frame_div_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d     = ST_START;
          shift_d     = fifo_mem[rd_ptr_q];
          frame_div_d = baud_div_q;
          tick_d      = baud_div_q - DIV_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          tick_d    = frame_div_q - DIV_ONE;
          bit_cnt_d = 3'd0;
        end else begin
          tick_d = tick_q - DIV_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          tick_d    = frame_div_q - DIV_ONE;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          tick_d = tick_q - DIV_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s && pop_s) begin
          state_d     = ST_START;
          shift_d     = fifo_mem[rd_ptr_q];
          frame_div_d = baud_div_q;
          tick_d      = baud_div_q - DIV_ONE;
        end else if (bit_end_s) begin
          state_d = ST_IDLE;
        end else begin
          tick_d = tick_q - DIV_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level follows the current state, giving the one-cycle register stage on tx.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= wdata[7:0];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= CNT_ZERO;
      overflow_q  <= 1'b0;
      baud_div_q  <= DIV_RST;
      frame_div_q <= DIV_RST;
      tick_q      <= DIV_ZERO;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      baud_div_q  <= baud_div_d;
      frame_div_q <= frame_div_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO limits and reset.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        tx;
  logic        irq;

  int passed;
  int total;

  mmio_uart_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Call at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [39:0] line;
    logic [9:0]  short_line;
    logic        irq_a, irq_b, busy_a, went_low;

    passed = 0; total = 0;
    sel = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0; rst_n = 1'b1;

    // 1: reset state
    @(negedge clk);
    do_reset();
    bus_read(4'h4, rd); check("rst_status", 64'(rd), 64'h4);
    bus_read(4'h8, rd); check("rst_bauddiv", 64'(rd), 64'd868);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_irq", 64'(irq), 64'd1);
    sel = 1'b1; #1; check("ready_sel1", 64'(ready), 64'd1);
    sel = 1'b0; #1; check("ready_sel0", 64'(ready), 64'd0);
    bus_read(4'hC, rd); check("unmapped_read", 64'(rd), 64'h0);

    // 2: single 0x55 frame at divisor 4
    @(negedge clk);
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, 32'h55);
    check("lat_tx_e0", 64'(tx), 64'd1);
    @(negedge clk);
    check("lat_tx_e1", 64'(tx), 64'd1);
    bus_read(4'h4, rd); check("frame_status_busy", 64'(rd), 64'h5);
    check("frame_irq_low", 64'(irq), 64'd0);
    irq_a = 1'b1; irq_b = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      line[39-k] = tx;
      if (k == 38) irq_a = irq;
      if (k == 39) irq_b = irq;
    end
    check("frame_55_line", 64'(line), 64'h0F0F0F0F0F);
    check("irq_during_stop", 64'(irq_a), 64'd0);
    check("irq_after_stop", 64'(irq_b), 64'd1);
    @(negedge clk);
    check("idle_tx_after", 64'(tx), 64'd1);
    bus_read(4'h4, rd); check("status_after_frame", 64'(rd), 64'h4);

    // 3: back-to-back 0xA5, 0x3C at divisor 2
    bus_write(4'h8, 32'd2);
    bus_write(4'h0, 32'hA5);
    bus_write(4'h0, 32'h3C);
    check("b2b_tx_pre", 64'(tx), 64'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      line[39-k] = tx;
    end
    check("b2b_line", 64'(line), 64'h330CF03FC3);
    repeat (3) @(negedge clk);
    check("b2b_irq_end", 64'(irq), 64'd1);

    // 4: FIFO full and overflow at divisor 100
    bus_write(4'h8, 32'd100);
    for (int i = 0; i < 9; i++) bus_write(4'h0, 32'(i + 1));
    bus_read(4'h4, rd); check("fifo_full_status", 64'(rd), 64'h803);
    bus_write(4'h0, 32'hEE);
    bus_read(4'h4, rd); check("overflow_set", 64'(rd), 64'h80B);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd); check("overflow_clear", 64'(rd), 64'h803);
    bus_read(4'h8, rd); check("baud_100", 64'(rd), 64'd100);
    bus_read(4'h0, rd); check("txdata_read0", 64'(rd), 64'h0);
    @(negedge clk);
    do_reset();
    bus_read(4'h4, rd); check("status_after_flush", 64'(rd), 64'h4);

    // 5: divisor 0 stored as 1, 0xFF frame is 10 cycles
    bus_write(4'h8, 32'd0);
    bus_read(4'h8, rd); check("baud_zero_as_one", 64'(rd), 64'd1);
    @(negedge clk);
    bus_write(4'h0, 32'hFF);
    @(negedge clk);
    irq_a = 1'b1; irq_b = 1'b0; busy_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      short_line[9-k] = tx;
      if (k == 7) irq_a = irq;
      if (k == 8) begin bus_read(4'h4, rd); busy_a = rd[0]; end
      if (k == 9) irq_b = irq;
    end
    check("ff_line", 64'(short_line), 64'h1FF);
    check("ff_irq_mid", 64'(irq_a), 64'd0);
    check("ff_busy_stop", 64'(busy_a), 64'd1);
    check("ff_irq_end", 64'(irq_b), 64'd1);

    // 6: reset during data bit 3 of a frame with bytes queued
    bus_write(4'h8, 32'd8);
    bus_write(4'h0, 32'h00);
    bus_write(4'h0, 32'h00);
    bus_write(4'h0, 32'h00);
    repeat (33) @(negedge clk);
    check("bit3_low", 64'(tx), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_tx_high", 64'(tx), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(4'h4, rd); check("post_reset_status", 64'(rd), 64'h4);
    check("post_reset_irq", 64'(irq), 64'd1);
    went_low = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) went_low = 1'b1;
    end
    check("no_resume", 64'(went_low), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter peripheral for soc_top; the SoC's outbound console path.
- The CPU writes bytes over the simple peripheral bus; the block buffers them in a small FIFO and serializes them as 8N1 frames on a single output line.
- Benches and off-chip logic decode the line to observe program output.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the TX FIFO (power of two, ≥2).
- DEFAULT_DIV, 868, reset value of the baud divisor in clock cycles per bit (100 MHz / 115200).
- DIV_W, 16, width of the baud divisor register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  1  peripheral select; bus access this cycle.
- we  input  1  1 = write, 0 = read (valid with sel).
- addr  input  4  byte offset: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational from addr.
- ready  output  1  access complete; tied to sel (single-cycle access).
- tx  output  1  serial line, idle high.
- irq  output  1  level interrupt, high while the FIFO is empty and the shifter is idle (all output drained).

Behaviour:
- Reset (async assert, sync release):
  - tx=1, irq=1, FIFO empty (count 0), overflow=0.
  - baud_div=DEFAULT_DIV, FSM=IDLE.
- Register map:
  - TXDATA write: pushes wdata[7:0]. TXDATA reads return 0.
  - STATUS read:
    - bit0 busy (FSM≠IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[11:8] FIFO count
    - all other bits 0
  - STATUS write: writing 1 to bit3 clears overflow. Other bits are ignored.
  - BAUDDIV read/write: wdata[DIV_W-1:0]. A written value of 0 is stored as 1.
  - Unmapped offsets read 0; writes to them are ignored.
- Push rule:
  - A push is accepted iff the FIFO is not full at the start of the cycle.
  - A push to a full FIFO is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave count unchanged.
- FSM states: IDLE → START → DATA → STOP → (IDLE or START).
  - IDLE: tx=1. When the FIFO is non-empty, pop the head into the shift register, latch baud_div for the frame, and go to START.
  - START: tx=0 for baud_div cycles.
  - DATA: 8 bits, LSB first, each held baud_div cycles. A 3-bit bit counter runs 0..7.
  - STOP: tx=1 for baud_div cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap);
    - otherwise go to IDLE.
  - tx is a registered output.
- Latency:
  - A TXDATA write accepted at edge E, with the FIFO empty and the FSM in IDLE, causes tx to fall at edge E+2.
  - The frame lasts exactly 10×baud_div cycles.
- BAUDDIV written mid-frame does not affect the current frame; it applies from the next frame's START.
- The bit-period counter counts baud_div-1 down to 0. The bit advances on 0.
- FIFO pointers are log2(FIFO_DEPTH)-bit and wrap modulo FIFO_DEPTH. Count is held separately, 0..FIFO_DEPTH.
- irq is combinational: empty && FSM==IDLE.
- Reset asserted mid-frame:
  - tx returns to 1 immediately (async).
  - Buffered bytes are discarded.
  - No partial frame resumes after release.

Test Plan:
1. Reset, then read STATUS -> 0x0000_0004 (empty only); BAUDDIV reads 868; tx=1; irq=1.
2. Write BAUDDIV=4, then write TXDATA=0x55 -> tx falls 2 cycles after the write. The line pattern, each level held 4 cycles, is 0,1,0,1,0,1,0,1,0,1. Total frame 40 cycles. busy=1 during the frame; irq returns to 1 after the stop bit.
3. BAUDDIV=2, write 0xA5 then 0x3C on consecutive cycles -> two frames back-to-back. The second start bit begins exactly 20 cycles after the first. No idle gap.
4. BAUDDIV=100, write 9 bytes quickly (FIFO_DEPTH=8) -> first byte popped into the shifter, 8 buffered, STATUS full=1, count=8, overflow=0. Then a 10th write -> overflow=1 and count unchanged. Write STATUS bit3=1 -> overflow=0.
5. BAUDDIV=0 written -> reads back 1. A byte 0xFF is then sent in 10 cycles: 1 low, then 9 high.
6. BAUDDIV=8, assert rst_n=0 during data bit 3 of a frame with 3 bytes queued -> tx=1 immediately, STATUS=0x4 after release, no further frames.
